// File: rtl/memory_bank.sv
// memory_bank
//   Single-port synchronous SRAM bank with a valid/ready request channel,
//   byte-strobed posted writes and a 2-entry read-response FIFO.
//
//   Optional feature macro: MEMORY_BANK_PARITY_EN
//     defined   : one even-parity bit per byte lane is stored with the data and
//                 checked on read; a mismatch raises rsp_err with that entry.
//     undefined : no parity storage, rsp_err tied low.
//
// Ports
//   clk        in   clock, all state on posedge
//   resetn     in   async active-low reset
//   req_valid  in   request present
//   req_ready  out  bank can accept a request (response buffer not full)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_wstrb  in   byte-lane write enables
//   rsp_valid  out  read data available
//   rsp_ready  in   consumer takes read data
//   rsp_rdata  out  read data at head of response buffer
//   rsp_err    out  parity error flag of head entry
module memory_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [1:0]            buf_err;
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;

   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  head;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_err;

   // req_ready depends only on registered state, never on rsp_ready.
   assign req_ready = (count != 2'd2);
   assign rsp_valid = (count != 2'd0);
   assign accept    = req_valid & req_ready;
   assign push      = accept & ~req_we;
   assign pop       = rsp_valid & rsp_ready;

   // Array: not reset, lanes written individually.
   always_ff @(posedge clk) begin
      if (accept && req_we) begin
         for (int i = 0; i < NB; i++) begin
            if (req_wstrb[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   assign rd_data = mem[req_addr];

`ifdef MEMORY_BANK_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] par_rd;

   always_ff @(posedge clk) begin
      if (accept && req_we) begin
         for (int i = 0; i < NB; i++) begin
            if (req_wstrb[i]) par_mem[req_addr][i] <= ^req_wdata[8*i +: 8];
         end
      end
   end

   assign par_rd = par_mem[req_addr];

   always_comb begin
      rd_err = 1'b0;
      for (int i = 0; i < NB; i++) begin
         rd_err = rd_err | ((^rd_data[8*i +: 8]) ^ par_rd[i]);
      end
   end
`else
   assign rd_err = 1'b0;
`endif

   // Response FIFO. Data slots are reset so rsp_rdata reads 0 out of reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 2; i++) buf_data[i] <= '0;
         buf_err <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            buf_data[wr_ptr] <= rd_data;
            buf_err[wr_ptr]  <= rd_err;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // When empty, the slot behind rd_ptr still holds the last popped entry,
   // which keeps rsp_rdata/rsp_err stable until the next push lands.
   assign head      = (count == 2'd0) ? ~rd_ptr : rd_ptr;
   assign rsp_rdata = buf_data[head];
   assign rsp_err   = buf_err[head];

endmodule

// File: tb/tb_memory_bank.sv
module tb_memory_bank;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks;
   int errors;

   memory_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request at a negedge, hold until accepted, release #1 after
   // the accepting posedge.
   task automatic issue(input logic we, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [9:0] a,
                             input logic [31:0] exp, input logic exp_err);
      issue(1'b0, a, 32'h0, 4'h0);
      check({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
      check({tag, "_data"}, {32'd0, rsp_rdata}, {32'd0, exp});
      check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b0;

      // 1: reset held 3 cycles
      repeat (3) @(negedge clk);
      check("rst_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("rst_err", {63'd0, rsp_err}, 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready}, 64'd1);

      // 2: full write then read
      issue(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
      check("wr_no_rsp", {63'd0, rsp_valid}, 64'd0);
      read_check("rd5", 10'd5, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      check("hold_valid", {63'd0, rsp_valid}, 64'd0);
      check("hold_rdata", {32'd0, rsp_rdata}, 64'h00000000DEADBEEF);

      // 3: partial write, plus wstrb=0 no-op
      issue(1'b1, 10'd5, 32'h11223344, 4'b0101);
      issue(1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000);
      read_check("part5", 10'd5, 32'hDE22BE44, 1'b0);

      // address wrap: top address distinct from 0
      issue(1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF);
      issue(1'b1, 10'h000, 32'h0BADC0DE, 4'hF);
      read_check("rd3ff", 10'h3FF, 32'hCAFEF00D, 1'b0);
      read_check("rd000", 10'h000, 32'h0BADC0DE, 1'b0);

      // 4: back-pressure
      issue(1'b1, 10'd1, 32'hA1A1A1A1, 4'hF);
      issue(1'b1, 10'd2, 32'hA2A2A2A2, 4'hF);
      issue(1'b1, 10'd3, 32'hA3A3A3A3, 4'hF);
      issue(1'b0, 10'd1, 32'h0, 4'h0);
      issue(1'b0, 10'd2, 32'h0, 4'h0);
      check("bp_full_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'd3;
      req_wdata = 32'hFFFFFFFF;
      req_wstrb = 4'hF;
      repeat (3) @(negedge clk);
      check("bp_stall_ready", {63'd0, req_ready}, 64'd0);
      check("bp_head1", {32'd0, rsp_rdata}, 64'h00000000A1A1A1A1);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_back", {63'd0, req_ready}, 64'd1);
      check("bp_head2", {32'd0, rsp_rdata}, 64'h00000000A2A2A2A2);
      @(negedge clk);
      req_valid = 1'b0;
      check("bp_valid3", {63'd0, rsp_valid}, 64'd1);
      check("bp_head3", {32'd0, rsp_rdata}, 64'h00000000A3A3A3A3);
      @(negedge clk);
      check("bp_empty", {63'd0, rsp_valid}, 64'd0);
      check("bp_hold3", {32'd0, rsp_rdata}, 64'h00000000A3A3A3A3);
      rsp_ready = 1'b0;

      // 5: streaming reads with simultaneous push/pop
      for (int i = 0; i < 8; i++)
         issue(1'b1, 10'(8 + i), 32'h50000000 + 32'(i * 17), 4'hF);
      @(negedge clk);
      rsp_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            check("st_valid", {63'd0, rsp_valid}, 64'd1);
            check("st_data", {32'd0, rsp_rdata}, {32'd0, 32'h50000000 + 32'((i - 1) * 17)});
            check("st_ready", {63'd0, req_ready}, 64'd1);
         end
         if (i < 8) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 10'(8 + i);
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("st_empty", {63'd0, rsp_valid}, 64'd0);
      rsp_ready = 1'b0;

      // 6: reset with two buffered reads
      issue(1'b0, 10'd5, 32'h0, 4'h0);
      issue(1'b0, 10'd1, 32'h0, 4'h0);
      check("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
      check("mid_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
      check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      read_check("post5", 10'd5, 32'hDE22BE44, 1'b0);
      read_check("post3", 10'd3, 32'hA3A3A3A3, 1'b0);

`ifdef MEMORY_BANK_PARITY_EN
      dut.par_mem[5] = dut.par_mem[5] ^ 4'b0100;
      read_check("par_bad", 10'd5, 32'hDE22BE44, 1'b1);
      read_check("par_ok", 10'd1, 32'hA1A1A1A1, 1'b0);
      issue(1'b1, 10'd5, 32'h01020304, 4'hF);
      read_check("par_fixed", 10'd5, 32'h01020304, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
